board_keeper: RTL and testbench

//  Consumer side of the controller cursor/write interface. Holds the 3x3 board.
//  On each new write request it places the current player's mark at the one-hot

---
 rtl/board_keeper.sv | 128 ++++++++++++
 tb/tb_board_keeper.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_keeper.sv
// Tic-tac-toe board holder: takes edge-detected write requests at the one-hot
// cursor, places alternating marks, then reports win, draw or reject.
module board_keeper #(
  parameter bit START_PLAYER = 1'b0,
  parameter bit AUTO_CLEAR   = 1'b0
) (
  input  logic       clk,
  input  logic       buttonResetN,
  input  logic [8:0] cursor,
  input  logic       write,
  output logic [8:0] boardX,
  output logic [8:0] boardO,
  output logic       turn,
  output logic       reject,
  output logic       gameOver,
  output logic [1:0] winner,
  output logic [8:0] winLine,
  output logic [3:0] moveCount
);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t     state_q;
  logic       writeQ;
  logic       reqQ;
  logic [8:0] boardX_q, boardO_q, winLine_q;
  logic       turn_q, reject_q, gameOver_q;
  logic [1:0] winner_q;
  logic [3:0] moveCount_q;

  logic [8:0] moverBoard;
  logic [8:0] winLine_d;
  logic       legal;

  assign legal      = $onehot(cursor) && ((cursor & (boardX_q | boardO_q)) == 9'h000);
  assign moverBoard = turn_q ? boardO_q : boardX_q;

  // Only the player who just moved can have completed a line, so a last-move
  // win is reported as a win rather than a draw.
  always_comb begin
    winLine_d = 9'h000;
    for (int i = 0; i < 8; i++) begin
      if ((moverBoard & LINES[i]) == LINES[i]) winLine_d = winLine_d | LINES[i];
    end
  end

  always_ff @(posedge clk or negedge buttonResetN) begin
    if (!buttonResetN) begin
      state_q     <= PLAY;
      writeQ      <= 1'b0;
      reqQ        <= 1'b0;
      boardX_q    <= 9'h000;
      boardO_q    <= 9'h000;
      winLine_q   <= 9'h000;
      turn_q      <= START_PLAYER;
      reject_q    <= 1'b0;
      gameOver_q  <= 1'b0;
      winner_q    <= 2'b00;
      moveCount_q <= 4'd0;
    end else begin
      writeQ   <= write;
      reqQ     <= write & ~writeQ;
      reject_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (reqQ) begin
            if (legal) begin
              if (turn_q) boardO_q <= boardO_q | cursor;
              else        boardX_q <= boardX_q | cursor;
              moveCount_q <= moveCount_q + 4'd1;
              state_q     <= CHECK;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (winLine_d != 9'h000) begin
            winner_q   <= turn_q ? 2'b10 : 2'b01;
            winLine_q  <= winLine_d;
            gameOver_q <= 1'b1;
            state_q    <= DONE;
          end else if (moveCount_q == 4'd9) begin
            winner_q   <= 2'b11;
            gameOver_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= PLAY;
          end
        end
        DONE: begin
          if (reqQ) begin
            if (AUTO_CLEAR) begin
              boardX_q    <= 9'h000;
              boardO_q    <= 9'h000;
              winLine_q   <= 9'h000;
              winner_q    <= 2'b00;
              moveCount_q <= 4'd0;
              gameOver_q  <= 1'b0;
              turn_q      <= START_PLAYER;
              state_q     <= PLAY;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign boardX    = boardX_q;
  assign boardO    = boardO_q;
  assign turn      = turn_q;
  assign reject    = reject_q;
  assign gameOver  = gameOver_q;
  assign winner    = winner_q;
  assign winLine   = winLine_q;
  assign moveCount = moveCount_q;

endmodule

// File: tb/tb_board_keeper.sv
// Bench for board_keeper: two instances (AUTO_CLEAR 0 and 1) share stimulus and
// are checked every cycle against a cell-array game model plus literal checks.
module tb_board_keeper;

  logic       clk;
  logic       buttonResetN;
  logic [8:0] cursor;
  logic       write;

  logic [1:0][8:0] bX, bO, wLine;
  logic [1:0]      trn, rej, over;
  logic [1:0][1:0] win;
  logic [1:0][3:0] cnt;

  int total;
  int bad;
  int rejCount0;

  board_keeper #(.START_PLAYER(1'b0), .AUTO_CLEAR(1'b0)) dut0 (
    .clk(clk), .buttonResetN(buttonResetN), .cursor(cursor), .write(write),
    .boardX(bX[0]), .boardO(bO[0]), .turn(trn[0]), .reject(rej[0]),
    .gameOver(over[0]), .winner(win[0]), .winLine(wLine[0]), .moveCount(cnt[0])
  );

  board_keeper #(.START_PLAYER(1'b0), .AUTO_CLEAR(1'b1)) dut1 (
    .clk(clk), .buttonResetN(buttonResetN), .cursor(cursor), .write(write),
    .boardX(bX[1]), .boardO(bO[1]), .turn(trn[1]), .reject(rej[1]),
    .gameOver(over[1]), .winner(win[1]), .winLine(wLine[1]), .moveCount(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game model: 0 empty, 1 X, 2 O per cell; index 0 = AUTO_CLEAR 0, 1 = AUTO_CLEAR 1.
  int   mCell [2][9];
  bit   mTurn [2];
  bit   mOver [2];
  bit   mRej  [2];
  bit   mEval [2];
  bit   mPend [2];
  int   mWin  [2];
  int   mCount[2];
  logic [8:0] mLine [2];
  bit   prevW;

  int lineTab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic clearGame(input int i);
    for (int c = 0; c < 9; c++) mCell[i][c] = 0;
    mTurn[i] = 1'b0; mOver[i] = 1'b0; mWin[i] = 0;
    mCount[i] = 0; mLine[i] = 9'h000;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      clearGame(i);
      mRej[i] = 1'b0; mEval[i] = 1'b0; mPend[i] = 1'b0;
    end
    prevW = 1'b0;
  endtask

  task automatic modelStep(input int i, input bit newReq);
    int mover, ones, idx;
    logic [8:0] line;
    mRej[i] = 1'b0;
    if (mEval[i]) begin
      mover = mTurn[i] ? 2 : 1;
      line  = 9'h000;
      for (int l = 0; l < 8; l++)
        if (mCell[i][lineTab[l][0]] == mover && mCell[i][lineTab[l][1]] == mover &&
            mCell[i][lineTab[l][2]] == mover)
          for (int k = 0; k < 3; k++) line[lineTab[l][k]] = 1'b1;
      if (line != 9'h000) begin
        mWin[i] = mover; mLine[i] = line; mOver[i] = 1'b1;
      end else if (mCount[i] == 9) begin
        mWin[i] = 3; mOver[i] = 1'b1;
      end else begin
        mTurn[i] = ~mTurn[i];
      end
      mEval[i] = 1'b0;
    end else if (mPend[i]) begin
      if (mOver[i]) begin
        if (i == 1) clearGame(i);
        else        mRej[i] = 1'b1;
      end else begin
        ones = 0; idx = 0;
        for (int c = 0; c < 9; c++) if (cursor[c]) begin ones++; idx = c; end
        if (ones == 1 && mCell[i][idx] == 0) begin
          mCell[i][idx] = mTurn[i] ? 2 : 1;
          mCount[i]++;
          mEval[i] = 1'b1;
        end else begin
          mRej[i] = 1'b1;
        end
      end
    end
    mPend[i] = newReq;
  endtask

  // Model advances on the same edges as the design; async reset handled separately.
  always @(posedge clk) begin
    if (!buttonResetN) begin
      modelReset();
    end else begin
      for (int i = 0; i < 2; i++) modelStep(i, write & ~prevW);
      prevW = write;
    end
  end

  always @(negedge buttonResetN) modelReset();

  function automatic logic [8:0] cellsOf(input int i, input int who);
    logic [8:0] v;
    v = 9'h000;
    for (int c = 0; c < 9; c++) if (mCell[i][c] == who) v[c] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from posedge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d.boardX", i),    int'(bX[i]),    int'(cellsOf(i, 1)));
      checkOutput($sformatf("dut%0d.boardO", i),    int'(bO[i]),    int'(cellsOf(i, 2)));
      checkOutput($sformatf("dut%0d.turn", i),      int'(trn[i]),   int'(mTurn[i]));
      checkOutput($sformatf("dut%0d.reject", i),    int'(rej[i]),   int'(mRej[i]));
      checkOutput($sformatf("dut%0d.gameOver", i),  int'(over[i]),  int'(mOver[i]));
      checkOutput($sformatf("dut%0d.winner", i),    int'(win[i]),   mWin[i]);
      checkOutput($sformatf("dut%0d.winLine", i),   int'(wLine[i]), int'(mLine[i]));
      checkOutput($sformatf("dut%0d.moveCount", i), int'(cnt[i]),   mCount[i]);
    end
    if (rej[0]) rejCount0++;
  end

  task automatic applyStimulus(input logic [8:0] cur, input int hold);
    @(posedge clk); #2;
    cursor = cur;
    write  = 1'b1;
    repeat (hold) @(posedge clk);
    #2 write = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk); #3;
    buttonResetN = 1'b0;
    repeat (2) @(posedge clk);
    #3 buttonResetN = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total = 0; bad = 0; rejCount0 = 0;
    buttonResetN = 1'b0; cursor = 9'h000; write = 1'b0;
    modelReset();
    doReset();
    #1;
    checkOutput("reset.boardX", int'(bX[0]), 0);
    checkOutput("reset.moveCount", int'(cnt[0]), 0);

    // Held write produces exactly one mark.
    applyStimulus(9'h010, 20);
    checkOutput("t1.boardX", int'(bX[0]), 'h010);
    checkOutput("t1.moveCount", int'(cnt[0]), 1);
    checkOutput("t1.turn", int'(trn[0]), 1);

    // Occupied cell then a non-one-hot cursor are both refused.
    applyStimulus(9'h010, 2);
    applyStimulus(9'h011, 2);
    checkOutput("t2.rejects", rejCount0, 2);
    checkOutput("t2.boardO", int'(bO[0]), 0);
    checkOutput("t2.turn", int'(trn[0]), 1);

    // X wins on the top row.
    doReset();
    applyStimulus(9'h001, 2);
    applyStimulus(9'h008, 2);
    applyStimulus(9'h002, 2);
    applyStimulus(9'h010, 2);
    applyStimulus(9'h004, 2);
    checkOutput("t3.winner", int'(win[0]), 1);
    checkOutput("t3.winLine", int'(wLine[0]), 'h007);
    checkOutput("t3.gameOver", int'(over[0]), 1);
    checkOutput("t3.turn", int'(trn[0]), 0);
    applyStimulus(9'h100, 2);
    checkOutput("t3.rejects", rejCount0, 3);
    checkOutput("t3.boardX", int'(bX[0]), 'h007);
    checkOutput("t3.boardO", int'(bO[0]), 'h018);
    checkOutput("t5.boardX", int'(bX[1]), 0);
    checkOutput("t5.gameOver", int'(over[1]), 0);
    checkOutput("t5.moveCount", int'(cnt[1]), 0);
    checkOutput("t5.turn", int'(trn[1]), 0);

    // Full board with no line is a draw.
    doReset();
    applyStimulus(9'h010, 2); applyStimulus(9'h001, 2);
    applyStimulus(9'h004, 2); applyStimulus(9'h040, 2);
    applyStimulus(9'h008, 2); applyStimulus(9'h020, 2);
    applyStimulus(9'h002, 2); applyStimulus(9'h080, 2);
    applyStimulus(9'h100, 2);
    checkOutput("t4.winner", int'(win[0]), 3);
    checkOutput("t4.moveCount", int'(cnt[0]), 9);
    checkOutput("t4.winLine", int'(wLine[0]), 0);

    // Asynchronous reset mid-game takes effect without a clock edge.
    doReset();
    applyStimulus(9'h001, 2);
    applyStimulus(9'h002, 2);
    @(posedge clk); #3;
    buttonResetN = 1'b0;
    #1;
    checkOutput("t6.boardX", int'(bX[0]), 0);
    checkOutput("t6.boardO", int'(bO[0]), 0);
    checkOutput("t6.moveCount", int'(cnt[0]), 0);
    checkOutput("t6.turn", int'(trn[0]), 0);
    repeat (2) @(posedge clk);
    #3 buttonResetN = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(9'h100, 2);
    checkOutput("t6.newMark", int'(bX[0]), 'h100);
    checkOutput("t6.turnAfter", int'(trn[0]), 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
